// File: rtl/mr_pkg.sv
// Shared constants and types for the Miller-Rabin entry sequencer.
// Key codes, FSM encoding and default operand sizes.
package mr_pkg;

  localparam int DIGITS_DEF = 9;
  localparam int N_W_DEF    = 30;

  localparam logic [3:0] KEY_CLR = 4'hC;
  localparam logic [3:0] KEY_ENT = 4'hD;

  typedef enum logic [2:0] {
    ST_ENTRY,
    ST_CONVERT,
    ST_LAUNCH,
    ST_WAIT,
    ST_RESULT
  } seq_st_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_serial_to_bin.sv
// Serial BCD to binary converter, one digit per enabled cycle, MSB first.
// acc presents the running value including the digit consumed this cycle.
module bcd_serial_to_bin
  import mr_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int N_W    = N_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         en,
  input  logic [$clog2(DIGITS+1)-1:0]  cnt,
  input  logic [4*DIGITS-1:0]          bcd,
  output logic [N_W-1:0]               acc,
  output logic                         done
);

  logic [N_W-1:0]              acc_q;
  logic [$clog2(DIGITS+1)-1:0] idx;
  logic [3:0]                  digit;

  assign digit = bcd[idx*4 +: 4];
  assign acc   = (acc_q << 3) + (acc_q << 1) + N_W'(digit);
  assign done  = en && (idx == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      idx   <= '0;
    end else if (start) begin
      acc_q <= '0;
      idx   <= cnt - 1'b1;
    end else if (en) begin
      acc_q <= acc;
      idx   <= idx - 1'b1;
    end
  end

endmodule

// File: rtl/mr_entry_sequencer.sv
// Keypad entry, BCD->binary conversion and Miller-Rabin launch/verdict hold.
// Optional engine watchdog enabled by defining MR_SEQ_TIMEOUT_EN.
module mr_entry_sequencer
  import mr_pkg::*;
#(
  parameter int          DIGITS  = DIGITS_DEF,
  parameter int          N_W     = N_W_DEF,
  parameter int unsigned TMO_CYC = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  output logic [4*DIGITS-1:0] bcd_disp,
  output logic [N_W-1:0]      mr_n,
  output logic                mr_start,
  input  logic                mr_ready,
  input  logic                mr_done,
  input  logic                mr_is_prime,
  output logic                mr_abort,
  output logic                busy,
  output logic                result_valid,
  output logic                result_prime,
  output logic                result_tmo
);

  localparam int CW = $clog2(DIGITS + 1);

  seq_st_t        state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [N_W-1:0] conv_acc;
  logic           conv_done;
  logic           conv_start;
  logic           key_dig, key_clr, key_ent;
  logic           tmo_hit;

  assign key_dig    = key_valid && is_digit(key_code);
  assign key_clr    = key_valid && (key_code == KEY_CLR);
  assign key_ent    = key_valid && (key_code == KEY_ENT);
  assign conv_start = (state == ST_ENTRY) && key_ent && (cnt != '0);

  bcd_serial_to_bin #(
    .DIGITS (DIGITS),
    .N_W    (N_W)
  ) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .en    (state == ST_CONVERT),
    .cnt   (cnt),
    .bcd   (bcd_disp),
    .acc   (conv_acc),
    .done  (conv_done)
  );

`ifdef MR_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != ST_WAIT) tmo_cnt <= '0;
    else                         tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (state == ST_WAIT) && (tmo_cnt == TW'(TMO_CYC - 1));
`else
  logic tmo_unused;
  assign tmo_unused = (TMO_CYC != 0);
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_ENTRY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_ENTRY:
        if (conv_start) state_nxt = ST_CONVERT;
      ST_CONVERT:
        if (key_clr)        state_nxt = ST_ENTRY;
        else if (conv_done) state_nxt = (conv_acc < N_W'(2)) ? ST_RESULT
                                                             : ST_LAUNCH;
      ST_LAUNCH:
        if (key_clr)       state_nxt = ST_ENTRY;
        else if (mr_ready) state_nxt = ST_WAIT;
      ST_WAIT:
        if (key_clr)                 state_nxt = ST_ENTRY;
        else if (mr_done || tmo_hit) state_nxt = ST_RESULT;
      ST_RESULT:
        if (key_dig || key_clr) state_nxt = ST_ENTRY;
      default:
        state_nxt = ST_ENTRY;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    mr_start = 1'b0;
    unique case (state)
      ST_CONVERT, ST_WAIT: busy = 1'b1;
      ST_LAUNCH: begin
        busy     = 1'b1;
        mr_start = 1'b1;
      end
      default: ;
    endcase
  end

  // Entry buffer, operand and verdict registers
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_disp     <= '0;
      cnt          <= '0;
      mr_n         <= '0;
      mr_abort     <= 1'b0;
      result_valid <= 1'b0;
      result_prime <= 1'b0;
      result_tmo   <= 1'b0;
    end else begin
      mr_abort <= 1'b0;
      unique case (state)
        ST_ENTRY:
          if (key_clr) begin
            bcd_disp <= '0;
            cnt      <= '0;
          end else if (key_dig && cnt < CW'(DIGITS)) begin
            bcd_disp <= {bcd_disp[4*DIGITS-5:0], key_code};
            cnt      <= cnt + 1'b1;
          end
        ST_CONVERT:
          if (key_clr) begin
            bcd_disp <= '0;
            cnt      <= '0;
          end else if (conv_done) begin
            mr_n <= conv_acc;
            if (conv_acc < N_W'(2)) begin
              result_valid <= 1'b1;
              result_prime <= 1'b0;
            end
          end
        ST_LAUNCH:
          if (key_clr) begin
            bcd_disp <= '0;
            cnt      <= '0;
          end
        ST_WAIT:
          if (key_clr) begin
            bcd_disp <= '0;
            cnt      <= '0;
            mr_abort <= 1'b1;
          end else if (mr_done) begin
            result_valid <= 1'b1;
            result_prime <= mr_is_prime;
          end else if (tmo_hit) begin
            mr_abort     <= 1'b1;
            result_valid <= 1'b1;
            result_prime <= 1'b0;
            result_tmo   <= 1'b1;
          end
        ST_RESULT:
          if (key_dig || key_clr) begin
            bcd_disp     <= key_dig ? (4*DIGITS)'(key_code) : '0;
            cnt          <= key_dig ? CW'(1) : '0;
            result_valid <= 1'b0;
            result_prime <= 1'b0;
            result_tmo   <= 1'b0;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mr_entry_sequencer.sv
// Randomized and directed bench for mr_entry_sequencer against a digit-queue model.
// Define MR_SEQ_TIMEOUT_EN to also exercise the watchdog with TMO_CYC=100.
module tb_mr_entry_sequencer;

  localparam int DIGITS = 9;
  localparam int N_W    = 30;
`ifdef MR_SEQ_TIMEOUT_EN
  localparam int unsigned TMO = 100;
`else
  localparam int unsigned TMO = 1000000;
`endif

  localparam int P_ENTRY  = 0;
  localparam int P_CONV   = 1;
  localparam int P_LAUNCH = 2;
  localparam int P_WAIT   = 3;
  localparam int P_RESULT = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                key_valid;
  logic [3:0]          key_code;
  logic [4*DIGITS-1:0] bcd_disp;
  logic [N_W-1:0]      mr_n;
  logic                mr_start;
  logic                mr_ready;
  logic                mr_done;
  logic                mr_is_prime;
  logic                mr_abort;
  logic                busy;
  logic                result_valid;
  logic                result_prime;
  logic                result_tmo;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: entered digits oldest-first plus a coarse phase
  logic [3:0]     q[$];
  int             ph;
  int             conv_left;
  int             wait_cyc;
  logic [N_W-1:0] m_n;
  logic           m_val, m_prime, m_tmo, m_abort;

  always #5 clk = ~clk;

  mr_entry_sequencer #(
    .DIGITS  (DIGITS),
    .N_W     (N_W),
    .TMO_CYC (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .bcd_disp     (bcd_disp),
    .mr_n         (mr_n),
    .mr_start     (mr_start),
    .mr_ready     (mr_ready),
    .mr_done      (mr_done),
    .mr_is_prime  (mr_is_prime),
    .mr_abort     (mr_abort),
    .busy         (busy),
    .result_valid (result_valid),
    .result_prime (result_prime),
    .result_tmo   (result_tmo)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [4*DIGITS-1:0] disp_of();
    logic [4*DIGITS-1:0] d = '0;
    foreach (q[i]) d = {d[4*DIGITS-5:0], q[i]};
    return d;
  endfunction

  function automatic longint value_of();
    longint v = 0;
    foreach (q[i]) v = v * 10 + longint'(q[i]);
    return v;
  endfunction

  task automatic model_clear_results();
    m_val = 0; m_prime = 0; m_tmo = 0;
  endtask

  task automatic model_step();
    logic dig, clr, ent;
    longint v;
    dig = key_valid && key_code <= 4'd9;
    clr = key_valid && key_code == 4'hC;
    ent = key_valid && key_code == 4'hD;
    m_abort = 0;
    if (rst) begin
      q.delete(); ph = P_ENTRY; m_n = '0;
      model_clear_results();
      return;
    end
    case (ph)
      P_ENTRY:
        if (dig && q.size() < DIGITS) q.push_back(key_code);
        else if (clr) q.delete();
        else if (ent && q.size() > 0) begin
          ph = P_CONV; conv_left = q.size();
        end
      P_CONV:
        if (clr) begin q.delete(); ph = P_ENTRY; end
        else begin
          conv_left--;
          if (conv_left == 0) begin
            v = value_of();
            m_n = N_W'(v);
            if (v < 2) begin ph = P_RESULT; m_val = 1; m_prime = 0; end
            else ph = P_LAUNCH;
          end
        end
      P_LAUNCH:
        if (clr) begin q.delete(); ph = P_ENTRY; end
        else if (mr_ready) begin ph = P_WAIT; wait_cyc = 0; end
      P_WAIT:
        if (clr) begin q.delete(); ph = P_ENTRY; m_abort = 1; end
        else if (mr_done) begin ph = P_RESULT; m_val = 1; m_prime = mr_is_prime; end
        else begin
          wait_cyc++;
`ifdef MR_SEQ_TIMEOUT_EN
          if (wait_cyc == int'(TMO)) begin
            ph = P_RESULT; m_abort = 1; m_val = 1; m_prime = 0; m_tmo = 1;
          end
`endif
        end
      default:
        if (dig) begin
          q.delete(); q.push_back(key_code); ph = P_ENTRY;
          model_clear_results();
        end else if (clr) begin
          q.delete(); ph = P_ENTRY;
          model_clear_results();
        end
    endcase
  endtask

  task automatic compare_all();
    chk("bcd_disp", bcd_disp, disp_of());
    chk("mr_n", mr_n, m_n);
    chk("mr_start", mr_start, ph == P_LAUNCH);
    chk("busy", busy, ph >= P_CONV && ph <= P_WAIT);
    chk("mr_abort", mr_abort, m_abort);
    chk("result_valid", result_valid, m_val);
    chk("result_prime", result_prime, m_prime);
    chk("result_tmo", result_tmo, m_tmo);
  endtask

  // One clock: apply inputs, step model at the edge, compare mid-cycle
  task automatic tick(input logic r, input logic kv, input logic [3:0] kc,
                      input logic rdy, input logic dn, input logic ip);
    rst = r; key_valid = kv; key_code = kc;
    mr_ready = rdy; mr_done = dn; mr_is_prime = ip;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic press(input logic [3:0] k);
    tick(0, 1, k, 0, 0, 0);
  endtask

  task automatic idle(input logic rdy);
    tick(0, 0, 4'h0, rdy, 0, 0);
  endtask

  initial begin
    q.delete(); ph = P_ENTRY; m_n = '0; conv_left = 0; wait_cyc = 0;
    m_abort = 0;
    model_clear_results();
    rst = 1; key_valid = 0; key_code = 0;
    mr_ready = 0; mr_done = 0; mr_is_prime = 0;
    repeat (3) tick(1, 0, 4'h0, 0, 0, 0);
    chk("rst_disp", bcd_disp, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", result_valid, 0);

    // 9,7,D: start at t+3 with operand 97, prime after 50 cycles
    press(4'd9); press(4'd7); press(4'hD);
    chk("t1_start_t1", mr_start, 0);
    idle(0);
    chk("t1_start_t2", mr_start, 0);
    idle(0);
    chk("t1_start_t3", mr_start, 1);
    chk("t1_n", mr_n, 97);
    chk("t1_model_n", m_n, 97);
    idle(1);
    chk("t1_accepted", mr_start, 0);
    repeat (49) idle(0);
    chk("t1_busy_wait", busy, 1);
    tick(0, 0, 4'h0, 0, 1, 1);
    chk("t1_valid", result_valid, 1);
    chk("t1_prime", result_prime, 1);
    press(4'hD);
    chk("t1_ent_ignored", result_valid, 1);

    // 1,D: composite by rule, no launch
    press(4'd1);
    chk("t2_disp", bcd_disp, 1);
    chk("t2_cleared", result_valid, 0);
    press(4'hD);
    idle(1);
    chk("t2_valid", result_valid, 1);
    chk("t2_prime", result_prime, 0);
    chk("t2_nostart", mr_start, 0);

    // Ten digits: the tenth is dropped
    press(4'hC);
    for (int i = 1; i <= 9; i++) press(4'(i));
    press(4'd1);
    chk("t3_disp", bcd_disp, 36'h123456789);
    press(4'hD);
    repeat (9) idle(0);
    chk("t3_start", mr_start, 1);
    chk("t3_n", mr_n, 123456789);
    idle(1);
    tick(0, 0, 4'h0, 0, 1, 0);
    chk("t3_valid", result_valid, 1);
    chk("t3_prime", result_prime, 0);

    // 5,6,1,D with engine stalled, then clear during WAIT
    press(4'hC);
    press(4'd5); press(4'd6); press(4'd1); press(4'hD);
    repeat (3) idle(0);
    chk("t4_start", mr_start, 1);
    repeat (20) idle(0);
    chk("t4_start_held", mr_start, 1);
    chk("t4_n", mr_n, 561);
    idle(1);
    chk("t4_single", mr_start, 0);
    idle(1);
    chk("t4_no_restart", mr_start, 0);
    press(4'hC);
    chk("t4_abort", mr_abort, 1);
    chk("t4_disp", bcd_disp, 0);
    idle(0);
    chk("t4_abort_pulse", mr_abort, 0);

    // Clear coincident with verdict: verdict discarded
    press(4'd3); press(4'd7); press(4'hD);
    repeat (2) idle(0);
    idle(1);
    tick(0, 1, 4'hC, 0, 1, 1);
    chk("t5_valid", result_valid, 0);
    chk("t5_abort", mr_abort, 1);

    // Reset during conversion
    press(4'd4); press(4'd2); press(4'hD);
    tick(1, 0, 4'h0, 0, 0, 0);
    chk("t6_disp", bcd_disp, 0);
    chk("t6_busy", busy, 0);
    chk("t6_n", mr_n, 0);
    chk("t6_abort", mr_abort, 0);

`ifdef MR_SEQ_TIMEOUT_EN
    // Silent engine: watchdog fires after TMO cycles in WAIT
    press(4'd1); press(4'd1); press(4'hD);
    repeat (2) idle(0);
    idle(1);
    repeat (99) idle(0);
    chk("t7_abort_early", mr_abort, 0);
    idle(0);
    chk("t7_abort", mr_abort, 1);
    chk("t7_tmo", result_tmo, 1);
    chk("t7_valid", result_valid, 1);
    chk("t7_prime", result_prime, 0);
    press(4'hC);
    chk("t7_tmo_clr", result_tmo, 0);
`endif

    // Random keys, engine handshakes and occasional resets
    for (int n = 0; n < 4000; n++) begin
      logic       kv, rdy, dn, r;
      logic [3:0] kc;
      kv  = ($urandom_range(3) == 0);
      kc  = 4'($urandom_range(15));
      if ($urandom_range(4) == 0) kc = 4'hD;
      if (kc == 4'hC && $urandom_range(2) != 0) kc = 4'($urandom_range(9));
      rdy = ($urandom_range(2) == 0);
      dn  = (ph == P_WAIT) ? ($urandom_range(7) == 0)
                           : ($urandom_range(15) == 0);
      r   = ($urandom_range(799) == 0);
      tick(r, kv, kc, rdy, dn, 1'($urandom_range(1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
